addsub_stage: RTL and testbench



---
 rtl/addsub_stage.sv | 195 +++++++++++++++++++
 tb/tb_addsub_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/addsub_stage.sv
// Two-stage add/subtract sequencer around an external combinational adder.
// Define ADDSUB_SKID_EN to replace the single output register with a 2-entry FIFO.
module addsub_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             clr_carry,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n,
  output logic             carry_q
);

  localparam int MSB = WIDTH - 1;
  localparam int PW  = WIDTH + 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             s1_valid_q, s1_valid_d;
  logic             carry_d;

  logic             space;
  logic             s1_adv;
  logic             accept;
  logic             res_v;
  logic             res_z;
  logic [PW-1:0]    res_pack;

  // bit 0 of the op selects subtract, bit 1 selects carry-chained forms
  always_comb begin
    add_x   = a_q;
    add_y   = op_q[0] ? ~b_q : b_q;
    add_cin = 1'b0;
    case (op_q)
      OP_ADD:  add_cin = 1'b0;
      OP_SUB:  add_cin = 1'b1;
      OP_ADC:  add_cin = carry_q;
      OP_SBC:  add_cin = carry_q;
      default: add_cin = 1'b0;
    endcase
  end

  always_comb begin
    res_z    = (add_s == '0);
    res_v    = (add_x[MSB] == add_y[MSB]) && (add_s[MSB] != add_x[MSB]);
    res_pack = {add_cout, res_v, res_z, add_s[MSB], add_s};
  end

  assign s1_adv   = s1_valid_q && space;
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    s1_valid_d = s1_valid_q;
    carry_d    = carry_q;
    if (accept) begin
      op_d       = op_e'(in_op);
      a_d        = in_a;
      b_d        = in_b;
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    // clear has priority so software can break a chain on the same cycle
    if (clr_carry) begin
      carry_d = 1'b0;
    end else if (s1_adv) begin
      carry_d = add_cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      s1_valid_q <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s1_valid_q <= s1_valid_d;
      carry_q    <= carry_d;
    end
  end

`ifdef ADDSUB_SKID_EN
  logic [1:0]    count_q, count_d;
  logic [PW-1:0] ent0_q, ent0_d;
  logic [PW-1:0] ent1_q, ent1_d;
  logic          pop;

  // registered count only, so in_ready never depends on out_ready
  assign space     = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    case ({s1_adv, pop})
      2'b10: begin
        if (count_q == 2'd0) ent0_d = res_pack;
        else                 ent1_d = res_pack;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        ent0_d  = ent1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          ent0_d = res_pack;
        end else begin
          ent0_d = ent1_q;
          ent1_d = res_pack;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      count_q <= count_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

  assign {out_c, out_v, out_z, out_n, out_result} = ent0_q;
`else
  logic          out_valid_q, out_valid_d;
  logic [PW-1:0] out_q, out_d;

  assign space = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (s1_adv) begin
      out_valid_d = 1'b1;
      out_d       = res_pack;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign {out_c, out_v, out_z, out_n, out_result} = out_q;
`endif

endmodule

// File: tb/tb_addsub_stage.sv
// Directed bench for addsub_stage; models the external 32-bit adder behaviourally.
module tb_addsub_stage;

  localparam int W = 32;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
`ifdef ADDSUB_SKID_EN
  localparam int HELD = 3;
`else
  localparam int HELD = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_op = 2'b00;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         clr_carry = 1'b0;
  logic [W-1:0] add_x, add_y, add_s;
  logic         add_cin, add_cout;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic         out_c, out_v, out_z, out_n;
  logic         carry_q;

  int nvec = 0;
  int nerr = 0;
  bit acc;
  logic [W+3:0] got[$];

  always #5 clk = ~clk;

  assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};

  addsub_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .clr_carry(clr_carry),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_c(out_c), .out_v(out_v), .out_z(out_z), .out_n(out_n),
    .carry_q(carry_q)
  );

  // one clock: sample handshakes mid-cycle, return just after the rising edge
  task automatic step();
    @(negedge clk);
    acc = in_valid && in_ready;
    if (out_valid && out_ready) got.push_back({out_c, out_v, out_z, out_n, out_result});
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    for (int i = 0; i < 40; i++) begin
      step();
      if (acc) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < 40 && got.size() < n; i++) step();
  endtask

  task automatic test_reset();
    #12;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    nvec++; if (carry_q !== 1'b0) begin nerr++; $display("FAIL reset_carry got %b want 0", carry_q); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    nvec++; if ({add_x, add_y, add_cin} !== {(2*W+1){1'b0}}) begin nerr++; $display("FAIL reset_adder_drive got %h %h %b want 0", add_x, add_y, add_cin); end
    nvec++; if ({out_c, out_v, out_z, out_n, out_result} !== {(W+4){1'b0}}) begin nerr++; $display("FAIL reset_result got %h want 0", {out_c, out_v, out_z, out_n, out_result}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_carry();
    got.delete();
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = OP_ADD; in_a = 32'hFFFF_FFFF; in_b = 32'h0000_0001;
    step();
    in_valid = 1'b0;
    nvec++; if (acc !== 1'b1) begin nerr++; $display("FAIL add_accept got %b want 1", acc); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL add_latency1 out_valid got %b want 0", out_valid); end
    step();
    nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL add_latency2 out_valid got %b want 1", out_valid); end
    nvec++; if (out_result !== 32'h0) begin nerr++; $display("FAIL add_result got %h want 00000000", out_result); end
    nvec++; if ({out_c, out_v, out_z, out_n} !== 4'b1010) begin nerr++; $display("FAIL add_flags cvzn got %b want 1010", {out_c, out_v, out_z, out_n}); end
    nvec++; if (carry_q !== 1'b1) begin nerr++; $display("FAIL add_carry_q got %b want 1", carry_q); end
    step();
  endtask

  task automatic test_sub();
    logic [W+3:0] exp [2];
    exp[0] = {4'b0001, 32'hFFFF_FFFE};
    exp[1] = {4'b1000, 32'h0000_0002};
    got.delete();
    send(OP_SUB, 32'd5, 32'd7);
    send(OP_SUB, 32'd7, 32'd5);
    drain(2);
    nvec++; if (got.size() != 2) begin nerr++; $display("FAIL sub_count got %0d want 2", got.size()); end
    else for (int i = 0; i < 2; i++) begin
      nvec++; if (got[i] !== exp[i]) begin nerr++; $display("FAIL sub_result[%0d] got %h want %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_chain();
    logic [W+3:0] exp [4];
    exp[0] = {4'b1010, 32'h0000_0000};
    exp[1] = {4'b0000, 32'h0000_0001};
    exp[2] = {4'b1010, 32'h0000_0000};
    exp[3] = {4'b0010, 32'h0000_0000};
    got.delete();
    send(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    send(OP_ADC, 32'h0, 32'h0);
    send(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    clr_carry = 1'b1;
    send(OP_ADC, 32'h0, 32'h0);
    clr_carry = 1'b0;
    drain(4);
    nvec++; if (got.size() != 4) begin nerr++; $display("FAIL chain_count got %0d want 4", got.size()); end
    else for (int i = 0; i < 4; i++) begin
      nvec++; if (got[i] !== exp[i]) begin nerr++; $display("FAIL chain_result[%0d] got %h want %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [W+3:0] exp [2];
    exp[0] = {4'b0101, 32'h8000_0000};
    exp[1] = {4'b1100, 32'h7FFF_FFFF};
    got.delete();
    send(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    send(OP_SUB, 32'h8000_0000, 32'h1);
    drain(2);
    nvec++; if (got.size() != 2) begin nerr++; $display("FAIL ovf_count got %0d want 2", got.size()); end
    else for (int i = 0; i < 2; i++) begin
      nvec++; if (got[i] !== exp[i]) begin nerr++; $display("FAIL ovf_result[%0d] got %h want %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    got.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = OP_ADD; in_a = 32'd1; in_b = 32'd1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (acc) begin
        idx++;
        in_a = idx + 1; in_b = idx + 1;
        if (idx == 4) in_valid = 1'b0;
      end
    end
    nvec++; if (idx != HELD) begin nerr++; $display("FAIL bp_accepts got %0d want %0d", idx, HELD); end
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    nvec++; if (out_valid !== 1'b1 || out_result !== 32'd2) begin nerr++; $display("FAIL bp_hold got %b/%h want 1/00000002", out_valid, out_result); end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      step();
      if (acc) begin
        idx++;
        in_a = idx + 1; in_b = idx + 1;
        if (idx == 4) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    drain(4);
    nvec++; if (got.size() != 4) begin nerr++; $display("FAIL bp_count got %0d want 4", got.size()); end
    else for (int i = 0; i < 4; i++) begin
      nvec++; if (got[i] !== {4'b0000, 32'(2 * (i + 1))}) begin nerr++; $display("FAIL bp_order[%0d] got %h want %h", i, got[i], 32'(2 * (i + 1))); end
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    send(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    send(OP_ADD, 32'd5, 32'd5);
    nvec++; if (out_valid !== 1'b1 || carry_q !== 1'b1) begin nerr++; $display("FAIL mid_pre got valid %b carry %b want 1 1", out_valid, carry_q); end
    #1 rst_n = 1'b0;
    #1;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
    nvec++; if (carry_q !== 1'b0) begin nerr++; $display("FAIL mid_carry got %b want 0", carry_q); end
    nvec++; if ({out_c, out_v, out_z, out_n, out_result} !== {(W+4){1'b0}}) begin nerr++; $display("FAIL mid_flags got %h want 0", {out_c, out_v, out_z, out_n, out_result}); end
    #1 rst_n = 1'b1;
    got.delete();
    out_ready = 1'b1;
    send(OP_ADC, 32'd3, 32'd4);
    drain(1);
    nvec++; if (got.size() != 1) begin nerr++; $display("FAIL mid_post_count got %0d want 1", got.size()); end
    else begin
      nvec++; if (got[0] !== {4'b0000, 32'd7}) begin nerr++; $display("FAIL mid_post_result got %h want 000000007", got[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub();
    test_chain();
    test_overflow();
    test_back_to_back();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
